// File: rtl/address_generation_unit_if.sv
// Address generator bus: the controller drives the run request and parameters,
// and the generator returns the current address.
interface address_generation_unit_if #(
    parameter int ADDR_W = 64
) ();
    logic              enable;
    logic [ADDR_W-1:0] start_address;
    logic [ADDR_W-1:0] generate_size;
    logic [ADDR_W-1:0] generated_address;

    // Controller side: requests runs and observes the address stream
    modport master (
        output enable,
        output start_address,
        output generate_size,
        input  generated_address
    );

    // Generator side: consumes requests and produces the address stream
    modport slave (
        input  enable,
        input  start_address,
        input  generate_size,
        output generated_address
    );
endinterface

// File: rtl/address_generation_unit.sv
// Sequential address generator: emits base, base+STRIDE, ... for a captured
// run length, one address per enabled clock. Enable low pauses a run, and
// the final address is held until enable drops and the block re-arms.
module address_generation_unit #(
    parameter int          ADDR_W = 64,
    parameter int unsigned STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    address_generation_unit_if.slave bus
);
    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] base_next;
    logic [ADDR_W-1:0] size_reg;
    logic [ADDR_W-1:0] size_next;
    logic [ADDR_W-1:0] offset_reg;
    logic [ADDR_W-1:0] offset_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;

    // A zero-length request is ignored so the block stays armed in IDLE.
    logic start_run;
    logic last_issue;

    assign start_run  = bus.enable && (bus.generate_size != '0);
    // The address being issued on this edge is the final one of the run.
    assign last_issue = bus.enable && (offset_reg == size_reg - ONE);

    assign bus.generated_address = addr_reg;

    // State register; reset asynchronously forces IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start, advance to DONE on last issue, re-arm on enable low.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_run) begin
                    state_next = (bus.generate_size == ONE) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath next values: capture at run start, step the address while enabled.
    always_comb begin
        base_next   = base_reg;
        size_next   = size_reg;
        offset_next = offset_reg;
        addr_next   = addr_reg;
        case (state_reg)
            IDLE: begin
                if (start_run) begin
                    base_next   = bus.start_address;
                    size_next   = bus.generate_size;
                    addr_next   = bus.start_address;
                    offset_next = ONE;
                end
            end
            RUN: begin
                if (bus.enable) begin
                    // Address is base + offset*STRIDE, wrapping modulo 2^ADDR_W;
                    // recomputing from the captured base keeps the stream
                    // tied to the captured parameters.
                    addr_next   = base_reg + offset_reg * STRIDE_W;
                    offset_next = offset_reg + ONE;
                end
            end
            default: begin
                // DONE holds everything; a new run only starts from IDLE.
            end
        endcase
    end

    // Datapath registers; reset clears the address, the counter and the captured inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_reg   <= '0;
            size_reg   <= '0;
            offset_reg <= '0;
            addr_reg   <= '0;
        end else begin
            base_reg   <= base_next;
            size_reg   <= size_next;
            offset_reg <= offset_next;
            addr_reg   <= addr_next;
        end
    end
endmodule

// File: tb/tb_address_generation_unit.sv
// Directed testbench for address_generation_unit: each step drives inputs,
// takes one rising edge, and checks the registered address 1 ns later.
module tb_address_generation_unit;
    localparam int ADDR_W = 64;

    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;

    address_generation_unit_if #(.ADDR_W(ADDR_W)) bus ();

    address_generation_unit #(
        .ADDR_W (ADDR_W),
        .STRIDE (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare the DUT output against a hand-computed value.
    task automatic check(input string tag, input logic [ADDR_W-1:0] expected);
        total_cnt++;
        assert (bus.generated_address === expected) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, bus.generated_address, expected);
        $display("check %-14s observed=%0h expected=%0h", tag, bus.generated_address, expected);
    endtask

    // Drive enable, take one edge, check the resulting address.
    task automatic step(input logic en, input string tag, input logic [ADDR_W-1:0] expected);
        bus.enable = en;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    task automatic set_run(input logic [ADDR_W-1:0] start, input logic [ADDR_W-1:0] size);
        bus.start_address = start;
        bus.generate_size = size;
    endtask

    // Async reset between edges: output must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        bus.enable = 1'b0;
        rst = 1'b1;
        #1;
        check(tag, 64'd0);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hold"}, 64'd0);
        rst = 1'b0;
        bus.enable = 1'b0;
    endtask

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        set_run(64'd0, 64'd0);
        #1;
        check("reset_async", 64'd0);
        // Enable high during reset: reset wins.
        bus.enable = 1'b1;
        set_run(64'd77, 64'd5);
        @(posedge clk);
        #1;
        check("reset_wins", 64'd0);
        rst = 1'b0;
        bus.enable = 1'b0;

        // Basic run
        set_run(64'd100, 64'd10);
        step(1'b1, "run_a0", 64'd100);
        step(1'b1, "run_a1", 64'd101);
        step(1'b1, "run_a2", 64'd102);
        step(1'b1, "run_a3", 64'd103);
        step(1'b1, "run_a4", 64'd104);

        // Mid-run reset, then fresh run
        pulse_reset("midrun_rst");
        set_run(64'd200, 64'd20);
        step(1'b1, "run_b0", 64'd200);
        step(1'b1, "run_b1", 64'd201);
        step(1'b1, "run_b2", 64'd202);
        step(1'b1, "run_b3", 64'd203);
        step(1'b1, "run_b4", 64'd204);
        pulse_reset("rearm_rst1");

        // Completion and hold
        set_run(64'd10, 64'd3);
        step(1'b1, "done_0", 64'd10);
        step(1'b1, "done_1", 64'd11);
        step(1'b1, "done_2", 64'd12);
        step(1'b1, "done_hold0", 64'd12);
        step(1'b1, "done_hold1", 64'd12);
        step(1'b1, "done_hold2", 64'd12);
        step(1'b0, "done_idle", 64'd12);
        set_run(64'd50, 64'd2);
        step(1'b1, "rerun_0", 64'd50);
        step(1'b1, "rerun_1", 64'd51);
        step(1'b0, "rerun_idle", 64'd51);

        // Pause
        set_run(64'd0, 64'd8);
        step(1'b1, "pause_0", 64'd0);
        step(1'b1, "pause_1", 64'd1);
        step(1'b0, "pause_2", 64'd1);
        step(1'b0, "pause_3", 64'd1);
        step(1'b1, "pause_4", 64'd2);
        pulse_reset("rearm_rst2");

        // Zero-length request is ignored; block stays in IDLE
        set_run(64'd7, 64'd1);
        step(1'b1, "single", 64'd7);
        step(1'b0, "single_idle", 64'd7);
        set_run(64'd99, 64'd0);
        step(1'b1, "size0_a", 64'd7);
        step(1'b1, "size0_b", 64'd7);
        set_run(64'd5, 64'd1);
        step(1'b1, "after_size0", 64'd5);
        step(1'b0, "after_idle", 64'd5);

        // Wrap past all-ones
        set_run(64'hFFFF_FFFF_FFFF_FFFE, 64'd4);
        step(1'b1, "wrap_0", 64'hFFFF_FFFF_FFFF_FFFE);
        step(1'b1, "wrap_1", 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, "wrap_2", 64'd0);
        step(1'b1, "wrap_3", 64'd1);
        step(1'b1, "wrap_hold", 64'd1);
        step(1'b0, "wrap_idle", 64'd1);

        // Input changes mid-run are ignored
        set_run(64'd1000, 64'd4);
        step(1'b1, "chg_0", 64'd1000);
        set_run(64'd5000, 64'd2);
        step(1'b1, "chg_1", 64'd1001);
        step(1'b1, "chg_2", 64'd1002);
        step(1'b1, "chg_3", 64'd1003);
        step(1'b1, "chg_hold", 64'd1003);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
